snake_game_ctrl: RTL and testbench

- Game-control stage downstream of the snake pixel generator. Consumes its per-pixel head/body flags.
- Places food and detects food, wall and self collisions once per frame.
- Drives `size` and the snake's reset back to the snake generator, and produces the final 12-bit RGB pixel for the VGA output stage.
- Owns the IDLE/PLAY/OVER game state, score and food placement.

---
 rtl/snake_game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game-control stage for the snake game: food placement, per-frame collision evaluation,
// score/size tracking and final pixel colour selection.
module snake_game_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned CELL      = 10,
    parameter int unsigned INIT_SIZE = 3,
    parameter int unsigned MAX_SIZE  = 31,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        snake_head,
    input  logic        snake_body,
    output logic [4:0]  size,
    output logic        snake_rst,
    output logic        game_over,
    output logic [7:0]  score,
    output logic        food_eaten,
    output logic [11:0] rgb
);

    typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

    localparam logic [5:0] FoodX0 = 6'd40;
    localparam logic [5:0] FoodY0 = 6'd30;

    state_e      state_q, state_d;
    logic [4:0]  size_q, size_d;
    logic [7:0]  score_q, score_d;
    logic        food_eaten_q, food_eaten_d;
    logic        snake_rst_q, snake_rst_d;
    logic        game_over_q, game_over_d;
    logic [11:0] rgb_q, rgb_d;
    logic [5:0]  cx_q, cx_d, cy_q, cy_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        hit_food_q, hit_food_d;
    logic        hit_body_q, hit_body_d;
    logic        hit_wall_q, hit_wall_d;
    logic [9:0]  pix_x_q, pix_y_q;
    logic        von_q;
    logic        start_q;

    logic        start_rise;
    logic [9:0]  food_x0, food_y0;
    logic        food_px, border;
    logic [5:0]  new_cx;
    logic        is_over;

    always_comb begin
        start_rise = start & ~start_q;
        food_x0    = 10'(cx_q) * 10'(CELL);
        food_y0    = 10'(cy_q) * 10'(CELL);
        // Strict bounds on both sides match the generator's square rendering.
        food_px    = (pix_x_q > food_x0) && (pix_x_q < food_x0 + 10'(CELL)) &&
                     (pix_y_q > food_y0) && (pix_y_q < food_y0 + 10'(CELL));
        border     = (pix_x_q < 10'(CELL)) || (pix_x_q >= 10'(H_ACTIVE - CELL)) ||
                     (pix_y_q < 10'(CELL)) || (pix_y_q >= 10'(V_ACTIVE - CELL));
        new_cx     = ((lfsr_q[5:0] == 6'd0) || (lfsr_q[5:0] == 6'd63)) ? 6'd32 : lfsr_q[5:0];
        is_over    = (state_q == StOver);
    end

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        score_d      = score_q;
        food_eaten_d = 1'b0;
        cx_d         = cx_q;
        cy_d         = cy_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        hit_food_d   = hit_food_q;
        hit_body_d   = hit_body_q;
        hit_wall_d   = hit_wall_q;

        // Frame-tick cycles fall in blanking, so accumulation there is skipped.
        if (state_q == StPlay && von_q && !frame_tick) begin
            hit_food_d = hit_food_q | (snake_head & food_px);
            hit_body_d = hit_body_q | (snake_head & snake_body);
            hit_wall_d = hit_wall_q | (snake_head & border);
        end

        case (state_q)
            StIdle, StOver: begin
                if (start_rise) begin
                    state_d    = StPlay;
                    size_d     = 5'(INIT_SIZE);
                    score_d    = 8'd0;
                    cx_d       = FoodX0;
                    cy_d       = FoodY0;
                    hit_food_d = 1'b0;
                    hit_body_d = 1'b0;
                    hit_wall_d = 1'b0;
                end
            end
            StPlay: begin
                if (frame_tick) begin
                    hit_food_d = 1'b0;
                    hit_body_d = 1'b0;
                    hit_wall_d = 1'b0;
                    if (hit_wall_q || hit_body_q) begin
                        state_d = StOver;
                    end else if (hit_food_q) begin
                        size_d       = (size_q < 5'(MAX_SIZE)) ? size_q + 5'd1 : size_q;
                        score_d      = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                        food_eaten_d = 1'b1;
                        cx_d         = new_cx;
                        cy_d         = {1'b0, lfsr_q[10:6]} + 6'd8;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        snake_rst_d = (state_q != StPlay);
        game_over_d = is_over;
        if (!von_q) begin
            rgb_d = 12'h000;
        end else if (snake_head) begin
            rgb_d = is_over ? 12'hF00 : 12'h0F0;
        end else if (snake_body) begin
            rgb_d = is_over ? 12'hA00 : 12'h0A0;
        end else if (food_px && state_q != StIdle) begin
            rgb_d = 12'hF00;
        end else if (border) begin
            rgb_d = 12'h888;
        end else begin
            rgb_d = is_over ? 12'h400 : 12'h000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            size_q       <= 5'(INIT_SIZE);
            score_q      <= 8'd0;
            food_eaten_q <= 1'b0;
            snake_rst_q  <= 1'b1;
            game_over_q  <= 1'b0;
            rgb_q        <= 12'h000;
            cx_q         <= FoodX0;
            cy_q         <= FoodY0;
            lfsr_q       <= LFSR_SEED;
            hit_food_q   <= 1'b0;
            hit_body_q   <= 1'b0;
            hit_wall_q   <= 1'b0;
            pix_x_q      <= 10'd0;
            pix_y_q      <= 10'd0;
            von_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            score_q      <= score_d;
            food_eaten_q <= food_eaten_d;
            snake_rst_q  <= snake_rst_d;
            game_over_q  <= game_over_d;
            rgb_q        <= rgb_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            lfsr_q       <= lfsr_d;
            hit_food_q   <= hit_food_d;
            hit_body_q   <= hit_body_d;
            hit_wall_q   <= hit_wall_d;
            pix_x_q      <= pixel_x;
            pix_y_q      <= pixel_y;
            von_q        <= video_on;
            start_q      <= start;
        end
    end

    assign size       = size_q;
    assign snake_rst  = snake_rst_q;
    assign game_over  = game_over_q;
    assign score      = score_q;
    assign food_eaten = food_eaten_q;
    assign rgb        = rgb_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: colour tables per game state plus hand-written
// sequences for eating, collisions, reset override and saturation.
module tb_snake_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic        video_on = 1'b0, frame_tick = 1'b0, start = 1'b0;
    logic        snake_head = 1'b0, snake_body = 1'b0;
    logic [4:0]  size;
    logic        snake_rst, game_over, food_eaten;
    logic [7:0]  score;
    logic [11:0] rgb;

    always #5 clk = ~clk;

    snake_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .start      (start),
        .snake_head (snake_head),
        .snake_body (snake_body),
        .size       (size),
        .snake_rst  (snake_rst),
        .game_over  (game_over),
        .score      (score),
        .food_eaten (food_eaten),
        .rgb        (rgb)
    );

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seeded during reset.
    logic [15:0] m_lfsr;
    always @(posedge clk)
        m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    typedef struct {
        int          ph;    // 0 idle, 1 play, 2 over
        int          x, y;
        logic        von, head, body;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[$];

    int total = 0, bad = 0;
    int fx, fy, esize, escore;
    logic [15:0] snap;
    logic [11:0] r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int ph, input int x, input int y, input logic von,
                       input logic head, input logic body, input logic [11:0] exp);
        vec_t v;
        v.ph = ph; v.x = x; v.y = y; v.von = von; v.head = head; v.body = body; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Present a pixel, then its head/body flags one clk later; return resulting rgb.
    task automatic pix(input int x, input int y, input logic von, input logic head,
                       input logic body, output logic [11:0] res);
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
        snake_head = 1'b0; snake_body = 1'b0;
        @(negedge clk);
        snake_head = head; snake_body = body;
        @(negedge clk);
        res = rgb;
        snake_head = 1'b0; snake_body = 1'b0; video_on = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        snap = m_lfsr;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic run_table(input int ph);
        logic [11:0] rr;
        foreach (vecs[i]) begin
            if (vecs[i].ph == ph) begin
                pix(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].head, vecs[i].body, rr);
                chk($sformatf("rgb vec%0d", i), 32'(rr), 32'(vecs[i].exp));
            end
        end
    endtask

    task automatic start_edge();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start size", 32'(size), 32'd3);
        chk("start score", 32'(score), 32'd0);
        chk("start rst lag", 32'(snake_rst), 32'd1);
        @(negedge clk);
        chk("play snake_rst", 32'(snake_rst), 32'd0);
        chk("play game_over", 32'(game_over), 32'd0);
        fx = 40; fy = 30; esize = 3; escore = 0;
    endtask

    task automatic eat();
        logic [11:0] rr;
        logic [5:0]  c;
        pix(fx * 10 + 5, fy * 10 + 5, 1'b1, 1'b1, 1'b0, rr);
        tick();
        esize  = (esize < 31) ? esize + 1 : 31;
        escore = (escore < 255) ? escore + 1 : 255;
        c = snap[5:0];
        fx = (c == 6'd0 || c == 6'd63) ? 32 : int'(c);
        fy = int'(snap[10:6]) + 8;
        chk("eat size", 32'(size), 32'(esize));
        chk("eat score", 32'(score), 32'(escore));
        chk("eat pulse", 32'(food_eaten), 32'd1);
        @(negedge clk);
        chk("eat pulse end", 32'(food_eaten), 32'd0);
    endtask

    initial begin
        add(0, 405, 305, 1, 0, 0, 12'h000);
        add(0,   5,   5, 1, 0, 0, 12'h888);
        add(0, 100, 100, 1, 1, 0, 12'h0F0);
        add(1, 100, 100, 1, 1, 0, 12'h0F0);
        add(1, 100, 100, 1, 0, 1, 12'h0A0);
        add(1, 405, 305, 1, 0, 0, 12'hF00);
        add(1, 401, 301, 1, 0, 0, 12'hF00);
        add(1, 409, 309, 1, 0, 0, 12'hF00);
        add(1, 400, 305, 1, 0, 0, 12'h000);
        add(1, 410, 305, 1, 0, 0, 12'h000);
        add(1, 405, 310, 1, 0, 0, 12'h000);
        add(1,   9, 200, 1, 0, 0, 12'h888);
        add(1,  10, 200, 1, 0, 0, 12'h000);
        add(1, 629, 200, 1, 0, 0, 12'h000);
        add(1, 630, 200, 1, 0, 0, 12'h888);
        add(1, 200, 469, 1, 0, 0, 12'h000);
        add(1, 200, 470, 1, 0, 0, 12'h888);
        add(1, 200,   9, 1, 0, 0, 12'h888);
        add(1, 405, 305, 0, 1, 0, 12'h000);
        add(2, 100, 100, 1, 0, 1, 12'hA00);
        add(2, 200, 200, 1, 0, 0, 12'h400);
        add(2,   5,   5, 1, 0, 0, 12'h888);
        add(2, 200, 200, 0, 0, 0, 12'h000);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst size", 32'(size), 32'd3);
        chk("rst score", 32'(score), 32'd0);
        chk("rst snake_rst", 32'(snake_rst), 32'd1);
        chk("rst game_over", 32'(game_over), 32'd0);
        chk("rst food_eaten", 32'(food_eaten), 32'd0);
        chk("rst rgb", 32'(rgb), 32'd0);
        reset = 1'b0;

        run_table(0);
        chk("idle snake_rst", 32'(snake_rst), 32'd1);

        // Start edge, then held high: no retrigger
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("start rst lag", 32'(snake_rst), 32'd1);
        @(negedge clk);
        chk("play snake_rst", 32'(snake_rst), 32'd0);
        repeat (100) @(negedge clk);
        chk("hold snake_rst", 32'(snake_rst), 32'd0);
        chk("hold game_over", 32'(game_over), 32'd0);
        chk("hold size", 32'(size), 32'd3);
        start = 1'b0;
        fx = 40; fy = 30; esize = 3; escore = 0;

        run_table(1);

        // Eat the initial food and find the relocated one on screen
        eat();
        chk("eat1 size", 32'(size), 32'd4);
        pix(fx * 10 + 5, fy * 10 + 5, 1'b1, 1'b0, 1'b0, r);
        chk("new food drawn", 32'(r), 32'hF00);
        if (fx != 40 || fy != 30) begin
            pix(405, 305, 1'b1, 1'b0, 1'b0, r);
            chk("old food gone", 32'(r), 32'h000);
        end

        // Wall collision
        pix(5, 200, 1'b1, 1'b1, 1'b0, r);
        chk("wall head rgb", 32'(r), 32'h0F0);
        tick();
        chk("wall size", 32'(size), 32'd4);
        chk("wall score", 32'(score), 32'd1);
        chk("wall no eat", 32'(food_eaten), 32'd0);
        chk("wall go lag", 32'(game_over), 32'd0);
        @(negedge clk);
        chk("wall game_over", 32'(game_over), 32'd1);
        chk("wall snake_rst", 32'(snake_rst), 32'd1);
        pix(100, 100, 1'b1, 1'b1, 1'b0, r);
        chk("over head rgb", 32'(r), 32'hF00);
        run_table(2);
        tick();
        chk("over hold size", 32'(size), 32'd4);
        chk("over hold score", 32'(score), 32'd1);

        // Restart: food back at (40,30); empty frame changes nothing
        start_edge();
        pix(405, 305, 1'b1, 1'b0, 1'b0, r);
        chk("food reset", 32'(r), 32'hF00);
        tick();
        chk("idle frame size", 32'(size), 32'd3);
        chk("idle frame eat", 32'(food_eaten), 32'd0);
        @(negedge clk);
        chk("idle frame go", 32'(game_over), 32'd0);

        // Head+body on food: game over wins, food not consumed
        pix(405, 305, 1'b1, 1'b1, 1'b1, r);
        chk("self head rgb", 32'(r), 32'h0F0);
        tick();
        chk("self size", 32'(size), 32'd3);
        chk("self score", 32'(score), 32'd0);
        chk("self no eat", 32'(food_eaten), 32'd0);
        @(negedge clk);
        chk("self no eat2", 32'(food_eaten), 32'd0);
        chk("self game_over", 32'(game_over), 32'd1);

        // Reset mid-PLAY with score 5, overriding frame_tick and start
        start_edge();
        repeat (5) eat();
        chk("score5", 32'(score), 32'd5);
        pix(fx * 10 + 5, fy * 10 + 5, 1'b1, 1'b1, 1'b0, r);
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
        chk("mid rst size", 32'(size), 32'd3);
        chk("mid rst score", 32'(score), 32'd0);
        chk("mid rst snake_rst", 32'(snake_rst), 32'd1);
        chk("mid rst game_over", 32'(game_over), 32'd0);
        chk("mid rst eat", 32'(food_eaten), 32'd0);
        chk("mid rst rgb", 32'(rgb), 32'd0);
        @(negedge clk);
        chk("mid rst eat2", 32'(food_eaten), 32'd0);
        chk("mid rst idle", 32'(snake_rst), 32'd1);
        start_edge();
        pix(405, 305, 1'b1, 1'b0, 1'b0, r);
        chk("rst food pos", 32'(r), 32'hF00);

        // Saturation of size and score
        repeat (255) eat();
        chk("sat size", 32'(size), 32'd31);
        chk("sat score", 32'(score), 32'd255);
        eat();
        chk("sat size hold", 32'(size), 32'd31);
        chk("sat score hold", 32'(score), 32'd255);
        pix(fx * 10 + 5, fy * 10 + 5, 1'b1, 1'b0, 1'b0, r);
        chk("sat food drawn", 32'(r), 32'hF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
